// File: rtl/cic_rate_ctrl_if.sv
// Control and configuration bundle around cic_rate_ctrl.
// master: the rate sequencer (drives the CIC/FIR config channels and status).
// slave : the surrounding control logic and filter IP config ports.
interface cic_rate_ctrl_if #(
  parameter int RATE_W    = 8,
  parameter int FIR_CFG_W = 8
);
  logic                 req_valid;
  logic [RATE_W-1:0]    req_rate;
  logic                 req_ready;
  logic                 req_err;
  logic [RATE_W-1:0]    cic_cfg_tdata;
  logic                 cic_cfg_tvalid;
  logic                 cic_cfg_tready;
  logic [FIR_CFG_W-1:0] fir_cfg_tdata;
  logic                 fir_cfg_tvalid;
  logic                 fir_cfg_tready;
  logic                 cic_out_tvalid;
  logic                 out_gate;
  logic                 busy;
  logic                 done;
  logic [RATE_W-1:0]    cur_rate;

  modport master (
    input  req_valid, req_rate, cic_cfg_tready, fir_cfg_tready, cic_out_tvalid,
    output req_ready, req_err, cic_cfg_tdata, cic_cfg_tvalid, fir_cfg_tdata,
           fir_cfg_tvalid, out_gate, busy, done, cur_rate
  );

  modport slave (
    output req_valid, req_rate, cic_cfg_tready, fir_cfg_tready, cic_out_tvalid,
    input  req_ready, req_err, cic_cfg_tdata, cic_cfg_tvalid, fir_cfg_tdata,
           fir_cfg_tvalid, out_gate, busy, done, cur_rate
  );
endinterface

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl: sequences a runtime decimation-rate change of the CIC decimator
// and its FIR compensator. A range-checked request is pushed to the CIC config
// channel, then (optionally) to the FIR coefficient-select channel, and the output
// stays blanked until SETTLE_SAMPLES fresh CIC samples have refilled the chain.
// Optional feature macro: RATECTL_FIR_CFG_EN (FIR coefficient-select stage).
// Without it the CIC handshake goes straight to settling and the FIR channel is held 0.
module cic_rate_ctrl #(
  parameter int RATE_W         = 8,
  parameter int FIR_CFG_W      = 8,
  parameter int RATE_MIN       = 4,
  parameter int RATE_MAX       = 32,
  parameter int RATE_DEFAULT   = 4,
  parameter int SETTLE_SAMPLES = 8,
  parameter int CFG_TIMEOUT    = 255
) (
  input logic            aclk,
  input logic            reset,
  cic_rate_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(CFG_TIMEOUT + 1);
  localparam int SET_W  = $clog2(SETTLE_SAMPLES + 1);

  localparam logic [RATE_W-1:0] RATE_MIN_W   = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] RATE_MAX_W   = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] RATE_DEF_W   = RATE_W'(RATE_DEFAULT);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(CFG_TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST  = SET_W'(SETTLE_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CIC_CFG,
    ST_FIR_CFG,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              err_nxt;
  logic              in_range;
  logic [RATE_W-1:0] rate_lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SET_W-1:0]  settle_cnt;

  // Saturating increment for the settle sample counter.
  function automatic logic [SET_W-1:0] sat_inc(input logic [SET_W-1:0] v);
    return (v == {SET_W{1'b1}}) ? v : v + 1'b1;
  endfunction

`ifdef RATECTL_FIR_CFG_EN
  // FIR coefficient bank for a decimation rate: <=4:0, <=8:1, <=16:2, else 3.
  function automatic logic [FIR_CFG_W-1:0] fir_sel(input logic [RATE_W-1:0] r);
    if (r <= RATE_W'(4))       return FIR_CFG_W'(0);
    else if (r <= RATE_W'(8))  return FIR_CFG_W'(1);
    else if (r <= RATE_W'(16)) return FIR_CFG_W'(2);
    else                       return FIR_CFG_W'(3);
  endfunction
`endif

  assign in_range = (bus.req_rate >= RATE_MIN_W) && (bus.req_rate <= RATE_MAX_W);

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode, request acceptance and error pulse generation.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          if (in_range) begin
            accept    = 1'b1;
            state_nxt = ST_CIC_CFG;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_CIC_CFG: begin
        if (bus.cic_cfg_tvalid && bus.cic_cfg_tready) begin
`ifdef RATECTL_FIR_CFG_EN
          state_nxt = ST_FIR_CFG;
`else
          state_nxt = ST_SETTLE;
`endif
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
`ifdef RATECTL_FIR_CFG_EN
      ST_FIR_CFG: begin
        if (bus.fir_cfg_tvalid && bus.fir_cfg_tready) begin
          state_nxt = ST_SETTLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
`endif
      ST_SETTLE: begin
        if (bus.cic_out_tvalid && (settle_cnt == SETTLE_LAST)) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Config-handshake wait counter, restarted on every state change.
  always_ff @(posedge aclk) begin
    if (reset)                                             wait_cnt <= '0;
    else if (state_nxt != state)                           wait_cnt <= '0;
    else if (state == ST_CIC_CFG || state == ST_FIR_CFG)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Settle counter: only CIC samples seen while settling are counted.
  always_ff @(posedge aclk) begin
    if (reset)                                        settle_cnt <= '0;
    else if (state != ST_SETTLE)                      settle_cnt <= '0;
    else if (bus.cic_out_tvalid)                      settle_cnt <= sat_inc(settle_cnt);
  end

  // Accepted rate; plain data register, only meaningful after an accept.
  always_ff @(posedge aclk) begin
    if (accept) rate_lat <= bus.req_rate;
  end

  // Registered status and CIC channel outputs, decoded from the next state.
  always_ff @(posedge aclk) begin
    if (reset) begin
      bus.req_ready      <= 1'b1;
      bus.req_err        <= 1'b0;
      bus.cic_cfg_tvalid <= 1'b0;
      bus.cic_cfg_tdata  <= '0;
      bus.out_gate       <= 1'b1;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.cur_rate       <= RATE_DEF_W;
    end else begin
      bus.req_ready      <= (state_nxt == ST_IDLE);
      bus.req_err        <= err_nxt;
      bus.cic_cfg_tvalid <= (state_nxt == ST_CIC_CFG);
      bus.out_gate       <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      bus.busy           <= (state_nxt != ST_IDLE);
      bus.done           <= (state_nxt == ST_DONE);
      if (accept)                 bus.cic_cfg_tdata <= bus.req_rate;
      if (state_nxt == ST_DONE)   bus.cur_rate      <= rate_lat;
    end
  end

`ifdef RATECTL_FIR_CFG_EN
  // FIR select channel; the select word is loaded on entry to FIR_CFG and held.
  always_ff @(posedge aclk) begin
    if (reset) begin
      bus.fir_cfg_tvalid <= 1'b0;
      bus.fir_cfg_tdata  <= '0;
    end else begin
      bus.fir_cfg_tvalid <= (state_nxt == ST_FIR_CFG);
      if (state_nxt == ST_FIR_CFG && state != ST_FIR_CFG) bus.fir_cfg_tdata <= fir_sel(rate_lat);
    end
  end
`else
  logic fir_tready_unused;

  assign bus.fir_cfg_tvalid = 1'b0;
  assign bus.fir_cfg_tdata  = '0;
  assign fir_tready_unused  = bus.fir_cfg_tready;
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Bench for cic_rate_ctrl: directed rate changes, illegal requests, timeouts,
// reset in mid-sequence and a randomized run, scored against a transaction-level model.
module tb_cic_rate_ctrl;

  localparam int RATE_W         = 8;
  localparam int FIR_CFG_W      = 8;
  localparam int RATE_MIN       = 4;
  localparam int RATE_MAX       = 32;
  localparam int RATE_DEFAULT   = 4;
  localparam int SETTLE_SAMPLES = 8;
  localparam int CFG_TIMEOUT    = 255;

  logic aclk = 1'b0;
  logic reset;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_rate;

  always #5 aclk = ~aclk;

  cic_rate_ctrl_if #(.RATE_W(RATE_W), .FIR_CFG_W(FIR_CFG_W)) bus ();

  cic_rate_ctrl #(
    .RATE_W(RATE_W), .FIR_CFG_W(FIR_CFG_W), .RATE_MIN(RATE_MIN), .RATE_MAX(RATE_MAX),
    .RATE_DEFAULT(RATE_DEFAULT), .SETTLE_SAMPLES(SETTLE_SAMPLES), .CFG_TIMEOUT(CFG_TIMEOUT)
  ) dut (
    .aclk (aclk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // FIR bank expected for a rate, written as a clamped log2 rather than a compare ladder.
  function automatic int fir_sel_model(input int r);
    int s;
    s = $clog2(r) - 2;
    if (s < 0) s = 0;
    if (s > 3) s = 3;
    return s;
  endfunction

  task automatic idle_inputs();
    bus.req_valid      = 1'b0;
    bus.req_rate       = '0;
    bus.cic_cfg_tready = 1'b0;
    bus.fir_cfg_tready = 1'b0;
    bus.cic_out_tvalid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  bus.req_ready, 1);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_cic_v"},  bus.cic_cfg_tvalid, 0);
    check({tag, "_fir_v"},  bus.fir_cfg_tvalid, 0);
    check({tag, "_gate"},   bus.out_gate, 1);
    check({tag, "_done"},   bus.done, 0);
    check({tag, "_err"},    bus.req_err, 0);
    check({tag, "_rate"},   bus.cur_rate, exp_rate);
  endtask

  // One request from IDLE. cic_dly/fir_dly: cycles the channel's tvalid is left
  // unanswered before tready is raised (>= CFG_TIMEOUT means never answered).
  // poke: fire a second request while settling, which must be refused.
  task automatic xfer(input int rate, input int cic_dly, input int fir_dly, input bit poke);
    int cyc, cic_hi, fir_hi, pulses, done_cnt, err_cnt, gate_bad, ctl_bad;
    int cdat_bad, fdat_bad, done_cyc, p8_cyc;
    bit settling, drove_cic_rdy, drove_fir_rdy, drove_pulse, saw_cic_v, saw_fir_v;
    bit finished, poked, legal, exp_to;
    legal = (rate >= RATE_MIN) && (rate <= RATE_MAX);
    check("pre_ready", bus.req_ready, 1);
    bus.req_rate  = RATE_W'(rate);
    bus.req_valid = 1'b1;
    @(negedge aclk);
    bus.req_valid = 1'b0;
    if (!legal) begin
      check("bad_err",   bus.req_err, 1);
      check("bad_cic_v", bus.cic_cfg_tvalid, 0);
      check("bad_busy",  bus.busy, 0);
      check("bad_ready", bus.req_ready, 1);
      @(negedge aclk);
      check_idle("bad_post");
      return;
    end
    cyc = 0; cic_hi = 0; fir_hi = 0; pulses = 0; done_cnt = 0; err_cnt = 0;
    gate_bad = 0; ctl_bad = 0; cdat_bad = 0; fdat_bad = 0; done_cyc = -1; p8_cyc = -2;
    settling = 0; drove_cic_rdy = 0; drove_fir_rdy = 0; drove_pulse = 0;
    saw_cic_v = 0; saw_fir_v = 0; finished = 0; poked = 0;
`ifdef RATECTL_FIR_CFG_EN
    exp_to = (cic_dly >= CFG_TIMEOUT) || (fir_dly >= CFG_TIMEOUT);
`else
    exp_to = (cic_dly >= CFG_TIMEOUT);
`endif
    while (!finished && cyc < 2000) begin
      // account for the edge that just passed
      if (drove_pulse && settling) begin
        pulses++;
        if (pulses == SETTLE_SAMPLES) p8_cyc = cyc;
      end
`ifdef RATECTL_FIR_CFG_EN
      if (drove_fir_rdy && saw_fir_v) settling = 1;
`else
      if (drove_cic_rdy && saw_cic_v) settling = 1;
`endif
      // observe
      saw_cic_v = bus.cic_cfg_tvalid;
      saw_fir_v = bus.fir_cfg_tvalid;
      if (saw_cic_v) begin
        cic_hi++;
        if (bus.cic_cfg_tdata !== RATE_W'(rate)) cdat_bad++;
      end
      if (saw_fir_v) begin
        fir_hi++;
        if (bus.fir_cfg_tdata !== FIR_CFG_W'(fir_sel_model(rate))) fdat_bad++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++; done_cyc = cyc; finished = 1;
        check("done_gate", bus.out_gate, 1);
        check("done_rate", bus.cur_rate, rate);
        check("done_busy", bus.busy, 1);
      end else if (bus.req_err === 1'b1) begin
        err_cnt++; finished = 1;
        check("to_gate",  bus.out_gate, 1);
        check("to_ready", bus.req_ready, 1);
        check("to_rate",  bus.cur_rate, exp_rate);
      end else begin
        if (bus.out_gate !== 1'b0) gate_bad++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) ctl_bad++;
      end
      // drive next edge
      drove_cic_rdy = saw_cic_v && (cic_hi > cic_dly);
      drove_fir_rdy = saw_fir_v && (fir_hi > fir_dly);
      bus.cic_cfg_tready = drove_cic_rdy;
      bus.fir_cfg_tready = drove_fir_rdy;
      drove_pulse = ($urandom_range(0, 1) == 1);
      bus.cic_out_tvalid = drove_pulse;
      if (poke && settling && !poked && !finished) begin
        poked = 1;
        bus.req_valid = 1'b1;
        bus.req_rate  = RATE_W'(9);
        check("poke_ready", bus.req_ready, 0);
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge aclk);
      cyc++;
    end
    idle_inputs();
    if (!finished) check("budget", 0, 1);
    if (exp_to) begin
      check("to_err",  err_cnt, 1);
      check("to_done", done_cnt, 0);
      if (cic_dly >= CFG_TIMEOUT) begin
        check("to_cic_hi", cic_hi, CFG_TIMEOUT);
        check("to_fir_hi", fir_hi, 0);
      end
`ifdef RATECTL_FIR_CFG_EN
      else begin
        check("cic_hi",     cic_hi, cic_dly + 1);
        check("to_fir_hi",  fir_hi, CFG_TIMEOUT);
      end
`endif
    end else begin
      check("err_cnt",  err_cnt, 0);
      check("done_cnt", done_cnt, 1);
      check("cic_hi",   cic_hi, cic_dly + 1);
`ifdef RATECTL_FIR_CFG_EN
      check("fir_hi",   fir_hi, fir_dly + 1);
`else
      check("fir_hi",   fir_hi, 0);
`endif
      check("done_at_last_sample", done_cyc, p8_cyc);
      exp_rate = rate;
    end
    check("cic_data",  cdat_bad, 0);
    check("fir_data",  fdat_bad, 0);
    check("gate_low",  gate_bad, 0);
    check("ctl_busy",  ctl_bad, 0);
    check_idle("post");
  endtask

  // Reset while a config channel is still waiting for tready.
  task automatic reset_mid(input int rate);
    int guard;
    bus.req_rate  = RATE_W'(rate);
    bus.req_valid = 1'b1;
    @(negedge aclk);
    bus.req_valid = 1'b0;
`ifdef RATECTL_FIR_CFG_EN
    bus.cic_cfg_tready = 1'b1;
    guard = 0;
    while (bus.fir_cfg_tvalid !== 1'b1 && guard < 20) begin
      @(negedge aclk);
      guard++;
    end
    bus.cic_cfg_tready = 1'b0;
    check("rm_fir_v", bus.fir_cfg_tvalid, 1);
`else
    guard = 3;
    repeat (guard) @(negedge aclk);
    check("rm_cic_v", bus.cic_cfg_tvalid, 1);
`endif
    check("rm_gate_low", bus.out_gate, 0);
    reset = 1'b1;
    @(negedge aclk);
    reset = 1'b0;
    exp_rate = RATE_DEFAULT;
    check_idle("rm_after");
    @(negedge aclk);
    check_idle("rm_after2");
  endtask

  initial begin
    int rate, cdly, fdly, gap;
    reset = 1'b1;
    idle_inputs();
    exp_rate = RATE_DEFAULT;
    repeat (3) @(negedge aclk);
    check_idle("rst");
    reset = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      check_idle("idle");
    end

    xfer(8, 0, 0, 0);
    xfer(3, 0, 0, 0);
    xfer(33, 0, 0, 0);
    xfer(16, CFG_TIMEOUT, 0, 0);
    xfer(16, 19, 0, 0);
`ifdef RATECTL_FIR_CFG_EN
    xfer(20, 0, CFG_TIMEOUT, 0);
`endif
    xfer(32, 1, 2, 1);
    repeat (3) begin
      @(negedge aclk);
      check_idle("after_poke");
    end
    reset_mid(24);
    xfer(4, 0, 0, 0);
    xfer(4, 2, 1, 0);
    xfer(0, 0, 0, 0);
    xfer(255, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      rate = $urandom_range(0, 40);
      cdly = ($urandom_range(0, 9) == 0) ? CFG_TIMEOUT : $urandom_range(0, 5);
      fdly = ($urandom_range(0, 9) == 0) ? CFG_TIMEOUT : $urandom_range(0, 5);
      xfer(rate, cdly, fdly, ($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge aclk);
        check_idle("gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
